// File: rtl/booth_r8_pp_accumulator_pkg.sv
// Shared types and sizing for the radix-8 Booth digit path (encoder and per-lane accumulator).
package booth_r8_pkg;
    localparam int A_W   = 12;
    localparam int B_W   = 12;
    localparam int NDIG  = (B_W + 2) / 3;
    localparam int P_W   = A_W + B_W;
    localparam int AX_W  = A_W + 1;
    localparam int PP_W  = A_W + 3;
    localparam int IDX_W = $clog2(NDIG);
    localparam int SH_W  = $clog2(3 * (NDIG - 1) + 1);

    typedef struct packed {
        logic       neg;
        logic [2:0] mag;
    } booth_digit_t;

    typedef enum logic [1:0] {
        MODE_INT8 = 2'd0,
        MODE_FP16 = 2'd1,
        MODE_BF16 = 2'd2,
        MODE_RSVD = 2'd3
    } booth_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRECOMP = 2'd1,
        ST_ACCUM   = 2'd2,
        ST_DONE    = 2'd3
    } acc_state_t;

    // Reserved mode falls through to the FP16 mantissa view.
    function automatic logic signed [AX_W-1:0] extend_operand(input logic [10:0] op_a,
                                                              input booth_mode_t mode);
        logic signed [AX_W-1:0] r;
        case (mode)
            MODE_INT8: r = {{(AX_W-8){op_a[7]}}, op_a[7:0]};
            MODE_BF16: r = {{(AX_W-8){1'b0}}, op_a[7:0]};
            default:   r = {{(AX_W-11){1'b0}}, op_a[10:0]};
        endcase
        return r;
    endfunction
endpackage

// File: rtl/booth_r8_pp_accumulator_if.sv
// Operand, digit-stream and product handshakes between the row encoder, one lane and the FMA adder.
interface booth_r8_pp_accumulator_if;
    import booth_r8_pkg::*;

    logic           op_valid;
    logic           op_ready;
    logic [A_W-1:0] op_a;
    logic [1:0]     op_mode;
    logic           dig_valid;
    logic           dig_ready;
    logic [3:0]     dig_code;
    logic           dig_last;
    logic           out_valid;
    logic           out_ready;
    logic [P_W-1:0] out_prod;
    logic           out_err;

    modport master (
        output op_valid, op_a, op_mode, dig_valid, dig_code, dig_last, out_ready,
        input  op_ready, dig_ready, out_valid, out_prod, out_err
    );

    modport slave (
        input  op_valid, op_a, op_mode, dig_valid, dig_code, dig_last, out_ready,
        output op_ready, dig_ready, out_valid, out_prod, out_err
    );
endinterface

// File: rtl/booth_r8_pp_select.sv
// Picks the Booth multiple {0,A,2A,3A,4A} for one digit and applies its sign.
module booth_r8_pp_select
    import booth_r8_pkg::*;
(
    input  logic signed [AX_W-1:0] a,
    input  logic signed [PP_W-1:0] a3,
    input  booth_digit_t           digit,
    output logic signed [PP_W-1:0] pp,
    output logic                   illegal
);
    logic signed [PP_W-1:0] a_ext;
    logic signed [PP_W-1:0] mult;

    assign a_ext = {{(PP_W-AX_W){a[AX_W-1]}}, a};

    always_comb begin
        mult    = '0;
        illegal = 1'b0;
        case (digit.mag)
            3'd0:    mult = '0;
            3'd1:    mult = a_ext;
            3'd2:    mult = a_ext <<< 1;
            3'd3:    mult = a3;
            3'd4:    mult = a_ext <<< 2;
            default: illegal = 1'b1;
        endcase
        pp = digit.neg ? -mult : mult;
    end
endmodule

// File: rtl/booth_r8_pp_accumulator.sv
// Per-lane radix-8 Booth partial-product accumulator: latch A, build 3A, shift-add one digit per cycle.
//  state      | meaning
//  ST_IDLE    | waiting for a multiplicand
//  ST_PRECOMP | registering 3A, clearing acc/idx
//  ST_ACCUM   | accepting one digit per cycle
//  ST_DONE    | product held until downstream accepts
module booth_r8_pp_accumulator
    import booth_r8_pkg::*;
(
    input  logic clk,
    input  logic rst,
    booth_r8_pp_accumulator_if.slave bus
);
    acc_state_t             state;
    acc_state_t             state_nxt;
    logic signed [AX_W-1:0] a_q;
    logic signed [PP_W-1:0] a3_q;
    logic signed [P_W-1:0]  acc_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   err_q;

    booth_digit_t           digit;
    logic signed [PP_W-1:0] pp;
    logic                   pp_illegal;
    logic signed [P_W-1:0]  pp_ext;
    logic signed [P_W-1:0]  pp_shifted;
    logic [SH_W-1:0]        shamt;
    logic                   op_fire;
    logic                   dig_fire;
    logic                   last_slot;
    logic                   unused_op_msb;

    assign digit         = booth_digit_t'(bus.dig_code);
    assign unused_op_msb = bus.op_a[A_W-1];
    assign last_slot     = (idx_q == IDX_W'(NDIG - 1));

    booth_r8_pp_select u_pp_select (
        .a       (a_q),
        .a3      (a3_q),
        .digit   (digit),
        .pp      (pp),
        .illegal (pp_illegal)
    );

    // Digit i carries weight 8**i.
    assign shamt      = SH_W'(idx_q) * SH_W'(3);
    assign pp_ext     = {{(P_W-PP_W){pp[PP_W-1]}}, pp};
    assign pp_shifted = pp_ext <<< shamt;

    assign bus.out_prod = acc_q;
    assign bus.out_err  = err_q;

    always_comb begin
        state_nxt     = state;
        bus.op_ready  = 1'b0;
        bus.dig_ready = 1'b0;
        bus.out_valid = 1'b0;
        op_fire       = 1'b0;
        dig_fire      = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.op_ready = 1'b1;
                if (bus.op_valid) begin
                    op_fire   = 1'b1;
                    state_nxt = ST_PRECOMP;
                end
            end
            ST_PRECOMP: state_nxt = ST_ACCUM;
            ST_ACCUM: begin
                bus.dig_ready = 1'b1;
                if (bus.dig_valid) begin
                    dig_fire = 1'b1;
                    if (bus.dig_last || last_slot) begin
                        state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            a_q   <= '0;
            a3_q  <= '0;
            acc_q <= '0;
            idx_q <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (op_fire) begin
                a_q   <= extend_operand(bus.op_a[10:0], booth_mode_t'(bus.op_mode));
                err_q <= (bus.op_mode == MODE_RSVD);
            end
            if (state == ST_PRECOMP) begin
                a3_q  <= {{(PP_W-AX_W){a_q[AX_W-1]}}, a_q} + ({{(PP_W-AX_W){a_q[AX_W-1]}}, a_q} <<< 1);
                acc_q <= '0;
                idx_q <= '0;
            end
            if (dig_fire) begin
                acc_q <= acc_q + pp_shifted;
                idx_q <= idx_q + 1'b1;
                // A full-length stream without a terminator is still accumulated but flagged.
                if (pp_illegal || (last_slot && !bus.dig_last)) begin
                    err_q <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_booth_r8_pp_accumulator.sv
// Directed plus randomized-INT8 scoreboard bench for the Booth radix-8 accumulator lane.
module tb_booth_r8_pp_accumulator;
    import booth_r8_pkg::*;

    typedef struct {
        logic [23:0] prod;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    booth_r8_pp_accumulator_if bus ();

    booth_r8_pp_accumulator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_op(input logic [11:0] a, input logic [1:0] mode);
        int g;
        g = 0;
        bus.op_valid = 1'b1;
        bus.op_a     = a;
        bus.op_mode  = mode;
        while (!bus.op_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) check("op_accept_timeout", 32'(bus.op_ready), 32'd1);
        @(negedge clk);
        bus.op_valid = 1'b0;
    endtask

    task automatic send_digit(input logic [3:0] code, input logic last);
        int g;
        g = 0;
        bus.dig_valid = 1'b1;
        bus.dig_code  = code;
        bus.dig_last  = last;
        while (!bus.dig_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) check("dig_accept_timeout", 32'(bus.dig_ready), 32'd1);
        @(negedge clk);
        bus.dig_valid = 1'b0;
        bus.dig_last  = 1'b0;
    endtask

    task automatic get_out(input string tag, input int hold);
        int   g;
        exp_t e;
        g = 0;
        while (!bus.out_valid && g < 100) begin
            @(negedge clk);
            g++;
        end
        check({tag, "_latency"}, 32'(g), 32'd0);
        check({tag, "_sb_nonempty"}, 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            for (int h = 0; h < hold; h++) begin
                bus.op_valid = 1'b1;
                bus.op_a     = 12'h123;
                bus.op_mode  = 2'd1;
                @(negedge clk);
                check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
                check({tag, "_hold_prod"}, 32'(bus.out_prod), 32'(e.prod));
                check({tag, "_hold_op_ready"}, 32'(bus.op_ready), 32'd0);
            end
            bus.op_valid = 1'b0;
            check({tag, "_prod"}, 32'(bus.out_prod), 32'(e.prod));
            check({tag, "_err"}, 32'(bus.out_err), 32'(e.err));
            check({tag, "_op_ready_low"}, 32'(bus.op_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_idle_op_ready"}, 32'(bus.op_ready), 32'd1);
        check({tag, "_idle_out_valid"}, 32'(bus.out_valid), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [11:0] a, input logic [1:0] mode,
                          input logic [3:0] c0, input logic [3:0] c1, input logic [3:0] c2,
                          input logic [3:0] c3, input int n, input bit term,
                          input logic [23:0] eprod, input logic eerr, input int hold);
        exp_t       e;
        logic [3:0] codes [4];
        codes[0] = c0;
        codes[1] = c1;
        codes[2] = c2;
        codes[3] = c3;
        e.prod   = eprod;
        e.err    = eerr;
        send_op(a, mode);
        sb.push_back(e);
        for (int i = 0; i < n; i++) begin
            send_digit(codes[i], (i == n - 1) && term);
        end
        get_out(tag, hold);
    endtask

    initial begin
        logic [11:0] ra;
        logic [3:0]  rc [4];
        logic [2:0]  rmag;
        logic        rneg;
        int          av;
        int          dv;
        int          rexp;
        int          rn;

        bus.op_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_mode   = '0;
        bus.dig_valid = 1'b0;
        bus.dig_code  = '0;
        bus.dig_last  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("rst_op_ready", 32'(bus.op_ready), 32'd1);
        check("rst_dig_ready", 32'(bus.dig_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_prod", 32'(bus.out_prod), 32'd0);
        check("rst_out_err", 32'(bus.out_err), 32'd0);

        // Digits offered in IDLE must be ignored.
        bus.dig_valid = 1'b1;
        bus.dig_code  = 4'b0001;
        bus.dig_last  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_dig_ready", 32'(bus.dig_ready), 32'd0);
            check("idle_out_valid", 32'(bus.out_valid), 32'd0);
        end
        bus.dig_valid = 1'b0;
        bus.dig_last  = 1'b0;

        run_op("fp16_a7", 12'd7, MODE_FP16, 4'b1011, 4'b0001, 4'b0000, 4'b0000, 4, 1'b1,
               24'h000023, 1'b0, 0);
        run_op("fp16_a100", 12'd100, MODE_FP16, 4'b0100, 4'b0000, 4'b0000, 4'b1100, 4, 1'b1,
               24'hFCE190, 1'b0, 0);
        run_op("int8_m3", 12'h0FD, MODE_INT8, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1, 1'b1,
               24'hFFFFFA, 1'b0, 0);
        run_op("illegal_mag", 12'd5, MODE_FP16, 4'b0001, 4'b0110, 4'b0000, 4'b0000, 4, 1'b1,
               24'h000005, 1'b1, 0);
        run_op("after_err", 12'd5, MODE_FP16, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 2, 1'b1,
               24'h000005, 1'b0, 0);
        run_op("hold_done", 12'h3FF, MODE_FP16, 4'b1010, 4'b0000, 4'b0000, 4'b0000, 1, 1'b1,
               24'hFFF802, 1'b0, 10);
        run_op("no_last", 12'd3, MODE_FP16, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4, 1'b0,
               24'd1755, 1'b1, 0);
        run_op("mode_rsvd", 12'hFFF, MODE_RSVD, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1, 1'b1,
               24'd2047, 1'b1, 0);
        run_op("bf16_zext", 12'hF80, MODE_BF16, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1, 1'b1,
               24'd128, 1'b0, 0);
        run_op("int8_min_neg4", 12'h080, MODE_INT8, 4'b1100, 4'b0000, 4'b0000, 4'b0000, 1, 1'b1,
               24'd512, 1'b0, 0);
        run_op("neg_zero", 12'd9, MODE_FP16, 4'b1000, 4'b0001, 4'b0000, 4'b0000, 2, 1'b1,
               24'd72, 1'b0, 0);

        // Reset in the middle of ACCUM aborts the op; nothing may come out.
        send_op(12'd9, MODE_FP16);
        sb.push_back('{24'd0, 1'b0});
        send_digit(4'b0001, 1'b0);
        send_digit(4'b0001, 1'b0);
        void'(sb.pop_back());
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_op_ready", 32'(bus.op_ready), 32'd1);
        check("midrst_dig_ready", 32'(bus.dig_ready), 32'd0);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_out_prod", 32'(bus.out_prod), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("midrst_quiet", 32'(bus.out_valid), 32'd0);
        end
        run_op("post_rst", 12'd9, MODE_FP16, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 1, 1'b1,
               24'd18, 1'b0, 0);

        for (int k = 0; k < 8; k++) begin
            ra   = 12'($urandom);
            av   = int'($signed(ra[7:0]));
            rn   = $urandom_range(1, 4);
            rexp = 0;
            for (int i = 0; i < 4; i++) begin
                rmag  = 3'($urandom_range(0, 4));
                rneg  = 1'($urandom_range(0, 1));
                rc[i] = {rneg, rmag};
                dv    = rneg ? -int'(rmag) : int'(rmag);
                if (i < rn) rexp += av * dv * (8 ** i);
            end
            run_op("rand_int8", ra, MODE_INT8, rc[0], rc[1], rc[2], rc[3], rn, 1'b1,
                   24'(rexp), 1'b0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end
endmodule
